i2c_regfile_peripheral: RTL and testbench

- Parametrised successor to the single-byte I2C peripheral.
- Oversamples SCL/SDA on the system clock and responds at a configurable 7-bit device address.
- Supports the standard register-pointer protocol into an internal NUM_REGS x 8 register file: write pointer then data; repeated START then read.
- Fabric reads the register file through a flat bus and gets a strobe on every I2C register write.

---
 rtl/i2c_regfile_peripheral.sv | 263 ++++++++++++++++++++++++++
 tb/tb_i2c_regfile_peripheral.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_peripheral.sv
// i2c_regfile_peripheral
//   I2C target with a NUM_REGS x 8 register file behind the usual register-pointer protocol:
//   [S][addr+W][ptr][data...][P] writes, [S][addr+W][ptr][Sr][addr+R][data...][P] reads.
//   SCL/SDA are oversampled on clk, so clk must run at least 8x the SCL rate.
//
//   Ports:
//     clk       system clock
//     rst       synchronous active-high reset
//     scl       I2C clock from the master
//     sda       I2C data; only ever driven to 0 or released (z)
//     regs      flat register file, reg i at [8i+7:8i]
//     wr_pulse  one-clk strobe per register written over I2C
//     wr_addr   pointer of the last register write
//     rw        R/W bit of the current addressed transfer (1 = read)
//     busy      high from address match until STOP, NACK-abort or START
//
//   Build option: define I2C_AUTOINC_EN to auto-increment the pointer after each written byte
//   and after each read byte the master ACKs.
module i2c_regfile_peripheral #(
    parameter logic [6:0]  DEV_ADDR    = 7'h42,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  OOR_DATA    = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_pulse,
    output logic [7:0]            wr_addr,
    output logic                  rw,
    output logic                  busy
);
    localparam int unsigned PTR_W = (NUM_REGS < 2) ? 1 : $clog2(NUM_REGS);

    localparam logic [3:0] StIdle     = 4'd0;
    localparam logic [3:0] StAddr     = 4'd1;
    localparam logic [3:0] StAddrAck  = 4'd2;
    localparam logic [3:0] StPtr      = 4'd3;
    localparam logic [3:0] StPtrAck   = 4'd4;
    localparam logic [3:0] StWdata    = 4'd5;
    localparam logic [3:0] StWdataAck = 4'd6;
    localparam logic [3:0] StRdata    = 4'd7;
    localparam logic [3:0] StRdataAck = 4'd8;
    localparam logic [3:0] StIgnore   = 4'd9;

    // Input synchronisers and edge / bus-condition detection
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // Protocol state
    logic [3:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       ack_rise_q, ack_rise_d;  // 9th-bit rising edge already seen
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       wr_en;
    logic [7:0] shift_in, rd_byte, ptr_inc;
    logic       in_range;

    logic [7:0] regs_q [NUM_REGS];
    logic       wr_pulse_q;
    logic [7:0] wr_addr_q;

    assign shift_in = {shift_q[6:0], sda_s};
    assign in_range = ({1'b0, ptr_q} < 9'(NUM_REGS));
    assign rd_byte  = in_range ? regs_q[ptr_q[PTR_W-1:0]] : OOR_DATA;

`ifdef I2C_AUTOINC_EN
    // In-range pointers wrap inside the file; out-of-range ones just count mod 256
    assign ptr_inc = (in_range && ptr_q == 8'(NUM_REGS - 1)) ? 8'd0 : ptr_q + 8'd1;
`else
    assign ptr_inc = ptr_q;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        ack_rise_d = ack_rise_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        wr_en      = 1'b0;

        // Bus conditions take priority over any bit edge in the same cycle
        if (start_det) begin
            state_d    = StAddr;
            bit_cnt_d  = 3'd0;
            oe_d       = 1'b0;
            ack_rise_d = 1'b0;
            busy_d     = 1'b0;
        end else if (stop_det) begin
            state_d    = StIdle;
            oe_d       = 1'b0;
            ack_rise_d = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StAddr) begin
                                if (shift_in[7:1] == DEV_ADDR) begin
                                    state_d = StAddrAck;
                                    rw_d    = shift_in[0];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = StIgnore;
                                end
                            end else if (state_q == StPtr) begin
                                ptr_d   = shift_in;
                                state_d = StPtrAck;
                            end else begin
                                wr_en   = in_range;
                                ptr_d   = ptr_inc;
                                state_d = StWdataAck;
                            end
                        end
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    // Drive ACK from the falling edge after bit 8 to the falling edge after bit 9
                    if (scl_rise) begin
                        ack_rise_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d       = 1'b0;
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            if (state_q == StAddrAck && rw_q) begin
                                state_d = StRdata;
                                shift_d = rd_byte;
                                oe_d    = ~rd_byte[7];
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StRdataAck;
                        end
                    end else if (scl_fall) begin
                        shift_d = {shift_q[6:0], shift_q[7]};
                        oe_d    = ~shift_q[6];
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = StIgnore;
                            busy_d  = 1'b0;
                            oe_d    = 1'b0;
                        end else begin
                            ack_rise_d = 1'b1;
                            ptr_d      = ptr_inc;
                        end
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            oe_d = 1'b0;  // release for the master's ACK bit
                        end else begin
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = 3'd0;
                            state_d    = StRdata;
                            shift_d    = rd_byte;
                            oe_d       = ~rd_byte[7];
                        end
                    end
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            ptr_q      <= 8'd0;
            oe_q       <= 1'b0;
            ack_rise_q <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            ack_rise_q <= ack_rise_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'd0;
            end
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 8'd0;
        end else begin
            wr_pulse_q <= wr_en;
            if (wr_en) begin
                regs_q[ptr_q[PTR_W-1:0]] <= shift_in;
                wr_addr_q                <= ptr_q;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        assign regs[8*gi +: 8] = regs_q[gi];
    end

    // Gated with rst so the bus is released in the same cycle reset is sampled
    assign sda      = (oe_q && !rst) ? 1'b0 : 1'bz;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_regfile_peripheral.sv
// Directed bench for i2c_regfile_peripheral (NUM_REGS=16, DEV_ADDR=7'h42).
// A behavioural I2C master bit-bangs scl/sda; a pullup resolves the open-drain sda line.
module tb_i2c_regfile_peripheral;
    localparam int unsigned NREGS = 16;
    localparam time         T     = 100ns;  // quarter-ish SCL phase, 10 clk periods

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               scl_m = 1'b1;
    logic               m_oe = 1'b0;
    wire                sda_bus;
    logic [NREGS*8-1:0] regs;
    logic               wr_pulse;
    logic [7:0]         wr_addr;
    logic               rw;
    logic               busy;

    assign sda_bus = m_oe ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_regfile_peripheral #(
        .DEV_ADDR   (7'h42),
        .NUM_REGS   (NREGS),
        .SYNC_STAGES(2),
        .OOR_DATA   (8'hFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl_m),
        .sda     (sda_bus),
        .regs    (regs),
        .wr_pulse(wr_pulse),
        .wr_addr (wr_addr),
        .rw      (rw),
        .busy    (busy)
    );

    always #5ns clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int         pulse_cnt = 0;
    logic [7:0] last_wr_addr = 8'd0;
    int         drive_cnt = 0;
    int         busy_cnt = 0;

    always @(posedge clk) begin
        if (wr_pulse === 1'b1) begin
            pulse_cnt    <= pulse_cnt + 1;
            last_wr_addr <= wr_addr;
        end
        if (!m_oe && sda_bus === 1'b0) drive_cnt <= drive_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    logic [7:0] exp_regs [NREGS];

    function automatic logic [NREGS*8-1:0] model_flat();
        logic [NREGS*8-1:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = exp_regs[i];
        return f;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Master primitives; each leaves scl low for at least T on exit (except stop)
    task automatic i2c_start();
        m_oe = 1'b0; scl_m = 1'b1; #T;
        m_oe = 1'b1; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic i2c_rstart();
        m_oe = 1'b0; #T;
        scl_m = 1'b1; #T;
        m_oe = 1'b1; #T;
        scl_m = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        m_oe = 1'b1; #T;
        scl_m = 1'b1; #T;
        m_oe = 1'b0; #T;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_oe = ~b[i]; #T;
            scl_m = 1'b1; #T;
            scl_m = 1'b0; #T;
        end
        m_oe = 1'b0; #T;
        scl_m = 1'b1; #(T/2);
        ack = (sda_bus === 1'b0);
        #(T/2);
        scl_m = 1'b0; #T;
    endtask

    task automatic read_bits(input int n, output logic [7:0] b);
        b = 8'd0;
        m_oe = 1'b0;
        for (int i = 0; i < n; i++) begin
            scl_m = 1'b1; #(T/2);
            b = {b[6:0], (sda_bus === 1'b1)};
            #(T/2);
            scl_m = 1'b0; #T;
        end
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        read_bits(8, b);
        m_oe = ~nack; #T;
        scl_m = 1'b1; #T;
        scl_m = 1'b0; #T;
        m_oe = 1'b0;
    endtask

    initial begin
        logic       a0, a1, a2;
        logic [7:0] rb, rb2;
        int         p0, d0, b0;

        for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'd0;
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #T;

        // Reset state
        check("rst_regs", regs, model_flat());
        check("rst_wr_pulse", wr_pulse, 1'b0);
        check("rst_wr_addr", wr_addr, 8'h00);
        check("rst_rw", rw, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda_bus, 1'b1);

        // Write regs[5] = 0x66
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h84, a0);
        check("wr_busy_after_match", busy, 1'b1);
        write_byte(8'h05, a1);
        write_byte(8'h66, a2);
        i2c_stop();
        exp_regs[5] = 8'h66;
        check("wr_acks", {a0, a1, a2}, 3'b111);
        check("wr_regs", regs, model_flat());
        check("wr_pulse_cycles", pulse_cnt - p0, 1);
        check("wr_addr_last", last_wr_addr, 8'h05);
        check("wr_busy_after_stop", busy, 1'b0);

        // Preload regs[5] = 0xAA, then read it back through a repeated START
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h05, a1);
        write_byte(8'hAA, a2);
        i2c_stop();
        exp_regs[5] = 8'hAA;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h05, a1);
        i2c_rstart();
        write_byte(8'h85, a2);
        check("rd_acks", {a0, a1, a2}, 3'b111);
        check("rd_rw", rw, 1'b1);
        read_byte(1'b1, rb);
        check("rd_byte", rb, 8'hAA);
        check("rd_busy_after_nack", busy, 1'b0);
        i2c_stop();

        // Address mismatch: 0x43+W
        d0 = drive_cnt;
        b0 = busy_cnt;
        i2c_start();
        write_byte(8'h86, a0);
        write_byte(8'h12, a1);
        i2c_stop();
        check("mm_acks", {a0, a1}, 2'b00);
        check("mm_no_drive", drive_cnt - d0, 0);
        check("mm_busy", busy_cnt - b0, 0);
        check("mm_regs", regs, model_flat());

        // Out-of-range pointer 0x67
        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h67, a1);
        write_byte(8'h66, a2);
        i2c_stop();
        check("oor_acks", {a0, a1, a2}, 3'b111);
        check("oor_no_pulse", pulse_cnt - p0, 0);
        check("oor_regs", regs, model_flat());
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h67, a1);
        i2c_rstart();
        write_byte(8'h85, a2);
        read_byte(1'b1, rb);
        i2c_stop();
        check("oor_read", rb, 8'hFF);

        // Two-byte write and read at ptr 0x0F
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h0F, a1);
        write_byte(8'h11, a2);
        write_byte(8'h22, a0);
        i2c_stop();
`ifdef I2C_AUTOINC_EN
        exp_regs[15] = 8'h11;
        exp_regs[0]  = 8'h22;
`else
        exp_regs[15] = 8'h22;
`endif
        check("multi_wr_regs", regs, model_flat());
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h0F, a1);
        i2c_rstart();
        write_byte(8'h85, a2);
        read_byte(1'b0, rb);
        read_byte(1'b1, rb2);
        i2c_stop();
`ifdef I2C_AUTOINC_EN
        check("multi_rd0", rb, 8'h11);
        check("multi_rd1", rb2, 8'h22);
`else
        check("multi_rd0", rb, 8'h22);
        check("multi_rd1", rb2, 8'h22);
`endif

        // Reset during RDATA bit 3 of 0xAA (a 0 bit, so sda is actively driven)
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h05, a1);
        i2c_rstart();
        write_byte(8'h85, a2);
        read_bits(3, rb);
        check("mid_rd_bits", rb, 8'h05);
        check("mid_rd_driving", sda_bus, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("mid_rst_sda", sda_bus, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = 8'd0;
        @(negedge clk);
        check("mid_rst_regs", regs, model_flat());
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rw", rw, 1'b0);
        scl_m = 1'b1; #T; #T;

        p0 = pulse_cnt;
        i2c_start();
        write_byte(8'h84, a0);
        write_byte(8'h03, a1);
        write_byte(8'h5A, a2);
        i2c_stop();
        exp_regs[3] = 8'h5A;
        check("post_rst_acks", {a0, a1, a2}, 3'b111);
        check("post_rst_regs", regs, model_flat());
        check("post_rst_pulse", pulse_cnt - p0, 1);
        check("post_rst_wr_addr", last_wr_addr, 8'h03);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
